// File: rtl/mov_up_seq.sv
// mov_up_seq: sequential 4x4 2048 "up" mover (tiles slide toward row 0); MOV_SCORE_EN enables the score accumulator
module mov_up_seq #(
    parameter int TILE_W   = 4,
    parameter int WIN_CODE = 11,
    parameter int SCORE_W  = 20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic [0:3][0:3][TILE_W-1:0]    i_grid_in,
    output logic [0:3][0:3][TILE_W-1:0]    o_grid_out,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_moved,
    output logic                           o_win,
    output logic [SCORE_W-1:0]             o_score
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic [0:3][TILE_W-1:0] col_t;

    localparam logic [TILE_W-1:0] Z  = '0;
    localparam logic [TILE_W-1:0] MX = '1;
    localparam logic [TILE_W-1:0] WC = TILE_W'(WIN_CODE);

    state_t                        r_state, w_state_nx;
    logic [2:0]                    r_step;
    logic [0:3][0:3][TILE_W-1:0]   r_grid, r_snap, w_cmp, w_mrg;
    logic                          r_busy, r_done, r_moved, r_win, w_moved, w_win;

    function automatic logic [TILE_W-1:0] inc(input logic [TILE_W-1:0] v);
        return (v == MX) ? v : v + TILE_W'(1);
    endfunction

    // first empty slot from the top is closed up; one slot per step
    function automatic col_t cmp_col(input col_t v);
        return (v[0] == Z) ? {v[1], v[2], v[3], Z} :
               (v[1] == Z) ? {v[0], v[2], v[3], Z} :
               (v[2] == Z) ? {v[0], v[1], v[3], Z} : v;
    endfunction

    // pairs merge greedily from the top; holes are removed by later compress steps
    function automatic col_t mrg_col(input col_t v);
        logic p01, p12, p23;
        p01 = (v[0] == v[1]) && (v[0] != Z);
        p12 = (v[1] == v[2]) && (v[1] != Z);
        p23 = (v[2] == v[3]) && (v[2] != Z);
        return p01 ? (p23 ? {inc(v[0]), Z, inc(v[2]), Z} : {inc(v[0]), Z, v[2], v[3]}) :
               p12 ? {v[0], inc(v[1]), Z, v[3]} :
               p23 ? {v[0], v[1], inc(v[2]), Z} : v;
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign w_cmp[c] = cmp_col(r_grid[c]);
        assign w_mrg[c] = mrg_col(r_grid[c]);
    end

    // win flag: any tile equal to the win code
    always_comb begin
        w_win = 1'b0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                w_win = w_win | (r_grid[c][r] == WC);
    end

    assign w_moved = (r_grid != r_snap);

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    // next state: accept start only in IDLE, run seven steps, one DONE cycle
    always_comb begin
        w_state_nx = r_state;
        if (r_state == IDLE && i_start)          w_state_nx = RUN;
        else if (r_state == RUN && r_step == 3'd6) w_state_nx = DONE;
        else if (r_state == DONE)                 w_state_nx = IDLE;
    end

    // board datapath and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grid  <= '0;
            r_snap  <= '0;
            r_step  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_moved <= 1'b0;
            r_win   <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (r_state == IDLE && i_start) begin
                r_grid  <= i_grid_in;
                r_snap  <= i_grid_in;
                r_step  <= '0;
                r_moved <= 1'b0;
                r_win   <= 1'b0;
                r_busy  <= 1'b1;
            end else if (r_state == RUN) begin
                r_grid <= (r_step == 3'd3) ? w_mrg : w_cmp;
                r_step <= r_step + 3'd1;
            end else if (r_state == DONE) begin
                r_busy  <= 1'b0;
                r_moved <= w_moved;
                r_win   <= w_win;
            end
        end
    end

`ifdef MOV_SCORE_EN
    localparam logic [SCORE_W:0] SMAX = {1'b0, {SCORE_W{1'b1}}};

    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W:0]   w_gain, w_sum;

    function automatic logic [SCORE_W:0] pw(input logic [TILE_W-1:0] n);
        return (SCORE_W + 1)'(1) << n;
    endfunction

    function automatic logic [SCORE_W:0] gain_col(input col_t v);
        logic p01, p12, p23;
        p01 = (v[0] == v[1]) && (v[0] != Z);
        p12 = (v[1] == v[2]) && (v[1] != Z);
        p23 = (v[2] == v[3]) && (v[2] != Z);
        return p01 ? pw(inc(v[0])) + (p23 ? pw(inc(v[2])) : '0) :
               p12 ? pw(inc(v[1])) :
               p23 ? pw(inc(v[2])) : '0;
    endfunction

    // total merge value of the current board across all columns
    always_comb begin
        w_gain = '0;
        for (int c = 0; c < 4; c++) w_gain = w_gain + gain_col(r_grid[c]);
    end

    assign w_sum = {1'b0, r_score} + w_gain;

    // saturating score, updated on the merge step only
    always_ff @(posedge clk) begin
        if (rst) r_score <= '0;
        else if (r_state == RUN && r_step == 3'd3) r_score <= (w_sum > SMAX) ? '1 : w_sum[SCORE_W-1:0];
    end

    assign o_score = r_score;
`else
    assign o_score = '0;
`endif

    assign o_grid_out = r_grid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_moved    = r_moved;
    assign o_win      = r_win;
endmodule
